// File: rtl/param_ld_ctr_pkg.sv
// -----------------------------------------------------------------------------
// param_ld_ctr_pkg
// Shared constants for the loadable up/down counter and its benches.
//   CTR_UP / CTR_DN     : values of the up_dn port
//   CTR_WRAP / CTR_SAT  : values of the sat port
// -----------------------------------------------------------------------------
package param_ld_ctr_pkg;

    localparam logic CTR_UP   = 1'b1;
    localparam logic CTR_DN   = 1'b0;
    localparam logic CTR_WRAP = 1'b0;
    localparam logic CTR_SAT  = 1'b1;

endpackage : param_ld_ctr_pkg

// File: rtl/param_ld_ctr_next.sv
// -----------------------------------------------------------------------------
// param_ld_ctr_next
// Combinational next-count and end-of-range logic for param_ld_ctr.
// Holds no state.
//   ctr    : current count (always < MODULUS)
//   up_dn  : count direction (CTR_UP / CTR_DN)
//   sat    : end-of-range mode (CTR_SAT holds, CTR_WRAP wraps)
//   nxt    : count value after one enabled step
//   at_end : ctr sits at the range end for the current direction
// -----------------------------------------------------------------------------
module param_ld_ctr_next
    import param_ld_ctr_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = longint'(1) << WIDTH
) (
    input  logic [WIDTH-1:0] ctr,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             at_end
);

    // One extra bit so that MODULUS = 2**WIDTH cannot alias to zero.
    localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] ctr_x;
    logic [WIDTH:0] nxt_x;

    always_comb begin
        ctr_x  = {1'b0, ctr};
        nxt_x  = ctr_x;
        at_end = 1'b0;
        if (up_dn == CTR_DN) begin
            at_end = (ctr_x == '0);
            if (!at_end)
                nxt_x = ctr_x - 1'b1;
            else if (sat != CTR_SAT)
                nxt_x = MOD_M1;
        end else begin
            at_end = (ctr_x == MOD_M1);
            if (!at_end)
                nxt_x = ctr_x + 1'b1;
            else if (sat != CTR_SAT)
                nxt_x = '0;
        end
        nxt = nxt_x[WIDTH-1:0];
    end

endmodule : param_ld_ctr_next

// File: rtl/param_ld_ctr.sv
// -----------------------------------------------------------------------------
// param_ld_ctr
// Loadable modulo-MODULUS up/down counter with wrap or saturate mode.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   en      : count enable
//   load    : synchronous parallel load (beats en)
//   l_data  : load value, clamped to MODULUS-1
//   up_dn   : 1 = count up, 0 = count down
//   sat     : 1 = saturate at range end, 0 = wrap
//   ctr     : registered count
//   tc      : combinational terminal count (en and at range end)
//   wrap    : registered one-cycle pulse after a wrap-around
//   sat_hit : sticky flag, set by a blocked count, cleared by load/reset
// -----------------------------------------------------------------------------
module param_ld_ctr
    import param_ld_ctr_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = longint'(1) << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] l_data,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] ctr,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_ld_ctr: WIDTH=%0d outside 2..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "param_ld_ctr: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(MODULUS - 1);

    // Out-of-range load values land on the top of the range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        if ({1'b0, d} >= MOD_W)
            return CTR_MAX;
        return d;
    endfunction

    logic [WIDTH-1:0] nxt;
    logic             at_end;

    param_ld_ctr_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .ctr    (ctr),
        .up_dn  (up_dn),
        .sat    (sat),
        .nxt    (nxt),
        .at_end (at_end)
    );

    assign tc = en && at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr     <= '0;
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (load) begin
            ctr     <= clamp_load(l_data);
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (en) begin
            ctr  <= nxt;
            wrap <= at_end && (sat == CTR_WRAP);
            if (at_end && (sat == CTR_SAT))
                sat_hit <= 1'b1;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule : param_ld_ctr

// File: tb/tb_param_ld_ctr.sv
// -----------------------------------------------------------------------------
// tb_param_ld_ctr
// Drives a WIDTH=4/MODULUS=10 counter and a WIDTH=3/MODULUS=8 counter with
// the same control stimulus and scoreboards both against a behavioural model.
// -----------------------------------------------------------------------------
module tb_param_ld_ctr;
    import param_ld_ctr_pkg::*;

    typedef struct {
        int ctr;
        bit wrap;
        bit sh;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic       up_dn = CTR_UP;
    logic       sat   = CTR_WRAP;
    logic [3:0] l_data_a = '0;
    logic [2:0] l_data_b = '0;

    logic [3:0] ctr_a;
    logic       tc_a, wrap_a, sh_a;
    logic [2:0] ctr_b;
    logic       tc_b, wrap_b, sh_b;

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   m_ctr[2];
    bit   m_sh[2];
    int   mod_v[2] = '{10, 8};

    param_ld_ctr #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .l_data(l_data_a),
        .up_dn(up_dn), .sat(sat), .ctr(ctr_a), .tc(tc_a), .wrap(wrap_a),
        .sat_hit(sh_a)
    );

    param_ld_ctr #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .l_data(l_data_b),
        .up_dn(up_dn), .sat(sat), .ctr(ctr_b), .tc(tc_b), .wrap(wrap_b),
        .sat_hit(sh_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctr[k] = 0;
            m_sh[k]  = 1'b0;
        end
    endtask

    function automatic bit exp_tc(input int k, input bit e, input bit u);
        if (!e) return 1'b0;
        return u ? (m_ctr[k] == mod_v[k] - 1) : (m_ctr[k] == 0);
    endfunction

    task automatic model_edge(input int k, input bit ld, input int ldd,
                              input bit e, input bit u, input bit s,
                              output exp_t x);
        x.wrap = 1'b0;
        if (ld) begin
            m_ctr[k] = (ldd >= mod_v[k]) ? mod_v[k] - 1 : ldd;
            m_sh[k]  = 1'b0;
        end else if (e) begin
            if (u) begin
                if (m_ctr[k] != mod_v[k] - 1) m_ctr[k] = m_ctr[k] + 1;
                else if (s)                   m_sh[k]  = 1'b1;
                else begin m_ctr[k] = 0; x.wrap = 1'b1; end
            end else begin
                if (m_ctr[k] != 0) m_ctr[k] = m_ctr[k] - 1;
                else if (s)        m_sh[k]  = 1'b1;
                else begin m_ctr[k] = mod_v[k] - 1; x.wrap = 1'b1; end
            end
        end
        x.ctr = m_ctr[k];
        x.sh  = m_sh[k];
    endtask

    // One clock of stimulus: check tc before the edge, push expectations,
    // then pop and compare the registered outputs just after the edge.
    task automatic step(input bit ld, input int ldd, input bit e, input bit u, input bit s);
        exp_t xa, xb, ga, gb;
        load     = ld;
        l_data_a = 4'(ldd);
        l_data_b = 3'(ldd);
        en       = e;
        up_dn    = u;
        sat      = s;
        #1;
        chk("tc_a", 32'(tc_a), 32'(exp_tc(0, e, u)));
        chk("tc_b", 32'(tc_b), 32'(exp_tc(1, e, u)));
        model_edge(0, ld, ldd, e, u, s, xa);
        model_edge(1, ld, ldd & 7, e, u, s, xb);
        q_a.push_back(xa);
        q_b.push_back(xb);
        @(posedge clk);
        #1;
        ga = q_a.pop_front();
        gb = q_b.pop_front();
        chk("ctr_a",     32'(ctr_a),  32'(ga.ctr));
        chk("wrap_a",    32'(wrap_a), 32'(ga.wrap));
        chk("sat_hit_a", 32'(sh_a),   32'(ga.sh));
        chk("ctr_b",     32'(ctr_b),  32'(gb.ctr));
        chk("wrap_b",    32'(wrap_b), 32'(gb.wrap));
        chk("sat_hit_b", 32'(sh_b),   32'(gb.sh));
    endtask

    initial begin
        model_reset();
        // Reset state, and tc follows it combinationally.
        #3;
        chk("rst_ctr_a",  32'(ctr_a),  32'd0);
        chk("rst_wrap_a", 32'(wrap_a), 32'd0);
        chk("rst_sh_a",   32'(sh_a),   32'd0);
        en    = 1'b1;
        up_dn = CTR_DN;
        #1;
        chk("rst_tc_a", 32'(tc_a), 32'd1);
        chk("rst_tc_b", 32'(tc_b), 32'd1);
        #6;
        rst = 1'b0;

        // Count up through the wrap: 0..9, 0, 1 (and 0..7, 0..3 on the 3-bit one).
        for (int i = 0; i < 11; i++) step(1'b0, 0, 1'b1, CTR_UP, CTR_WRAP);

        // Over-range load clamps to 9, no wrap on the load cycle, then count down.
        step(1'b1, 13, 1'b1, CTR_DN, CTR_WRAP);
        chk("ld_clamp_a", 32'(ctr_a),  32'd9);
        chk("ld_wrap_a",  32'(wrap_a), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, CTR_DN, CTR_WRAP);
        chk("at_six_a", 32'(ctr_a), 32'd6);

        // Asynchronous reset mid-cycle.
        #3;
        rst = 1'b1;
        #1;
        chk("async_ctr_a", 32'(ctr_a), 32'd0);
        chk("async_ctr_b", 32'(ctr_b), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        step(1'b0, 0, 1'b1, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_DN, CTR_WRAP);

        // Saturate at 0 counting down, then load wins over en and clears sat_hit.
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, CTR_DN, CTR_SAT);
        chk("sat_sticky_a", 32'(sh_a), 32'd1);
        step(1'b1, 5, 1'b1, CTR_DN, CTR_SAT);
        chk("ld_win_a", 32'(ctr_a), 32'd5);

        // Down-wrap from 0 to MODULUS-1.
        step(1'b1, 0, 1'b0, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_DN, CTR_WRAP);

        // Saturate at the top counting up; load in a blocked cycle clears sat_hit.
        step(1'b0, 0, 1'b1, CTR_UP, CTR_SAT);
        step(1'b0, 0, 1'b1, CTR_UP, CTR_SAT);
        step(1'b1, 9, 1'b1, CTR_UP, CTR_SAT);

        // Hold, load without en, direction changes.
        step(1'b0, 0, 1'b0, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b0, CTR_DN, CTR_WRAP);
        step(1'b1, 3, 1'b0, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_DN, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_UP, CTR_WRAP);

        // Top-of-range load then up-wrap on both counters; pulse lasts one cycle.
        step(1'b1, 15, 1'b0, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b1, CTR_UP, CTR_WRAP);
        step(1'b0, 0, 1'b0, CTR_UP, CTR_WRAP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_param_ld_ctr
